seg_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of common-anode 7-segment digits. Takes NUM_DIGITS packed BCD values with per-digit decimal points, decodes them to active-low segment patterns, and scans one anode at a time at a programmable rate. Adds tear-free input loading, leading-zero blanking, per-digit blinking and an anode-off guard interval against ghosting. Sits between the stopwatch/timer counters and the board's AN/SEG pins.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_digit_lut.sv | 21 ++
 rtl/seg_scan_driver.sv | 143 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and segment patterns for the multiplexed 7-segment driver.
// Patterns are active-low {g,f,e,d,c,b,a}; seg_t adds the dp bit on top.
package seg_pkg;

    typedef logic [7:0] seg_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam seg_t       SEG_OFF   = 8'hFF;

    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage

// File: rtl/seg_digit_lut.sv
// BCD code plus active-low dp to active-low segment byte.
// Codes A-F blank the segments but still pass the decimal point through.
module seg_digit_lut
    import seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        // NOTE: assign every output a default first so no path leaves it unassigned (no latch).
        seg = {dp, SEG_BLANK};
        for (int i = 0; i < 10; i++) begin
            if (code == 4'(i)) begin
                seg = {dp, SEG_DIGITS[i]};
            end
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with tear-free loading,
// leading-zero blanking, per-digit blink and an anode-off guard at slot start.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD        = 500,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        idx;
    logic [FRM_W-1:0]        frame_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] shadow_bcd;
    logic [4*NUM_DIGITS-1:0] disp_bcd;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   disp_dp;

    logic                    slot_last;
    logic                    frame_last;
    logic                    blink_last;
    logic                    in_guard;
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_lead;
    logic                    cur_blink;
    seg_t                    lut_seg;
    seg_t                    seg_next;

    assign slot_last  = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
    assign frame_last = slot_last && (idx == IDX_W'(NUM_DIGITS - 1));
    assign blink_last = (frame_cnt == FRM_W'(BLINK_FRAMES - 1));

    generate
        if (GUARD > 0) begin : g_guard
            assign in_guard = (slot_cnt < SLOT_W'(GUARD));
        end else begin : g_no_guard
            assign in_guard = 1'b0;
        end
    endgenerate

    // A digit is a leading zero when it and every digit to its left are 0 with dp off.
    always_comb begin : lz_scan
        logic run;
        // NOTE: 'run' is a combinational temporary, so blocking '=' is correct here.
        run       = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run          = run && (disp_bcd[4*i +: 4] == 4'd0) && disp_dp[i];
            lead_zero[i] = run && (i != 0);
        end
    end

    always_comb begin : digit_mux
        cur_code  = '0;
        cur_dp    = 1'b1;
        cur_lead  = 1'b0;
        cur_blink = 1'b0;
        an_sel    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_code  = disp_bcd[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_lead  = lead_zero[i];
                cur_blink = blink_mask[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    seg_digit_lut u_lut (
        .code (cur_code),
        .dp   (cur_dp),
        .seg  (lut_seg)
    );

    always_comb begin : out_sel
        an_next  = '1;
        seg_next = SEG_OFF;
        if (!in_guard) begin
            an_next = an_sel;
            if (!(lz_blank && cur_lead) && !(blink_phase && cur_blink)) begin
                seg_next = lut_seg;
            end
        end
    end

    // NOTE: all state below uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt    <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            shadow_bcd  <= '0;
            shadow_dp   <= '1;
            disp_bcd    <= '0;
            disp_dp     <= '1;
            an          <= '1;
            seg         <= SEG_OFF;
        end else begin
            slot_cnt <= slot_last ? '0 : slot_cnt + 1'b1;
            if (slot_last) begin
                idx <= frame_last ? '0 : idx + 1'b1;
            end
            if (load) begin
                shadow_bcd <= bcd;
                shadow_dp  <= dp;
            end
            // A load on the wrap edge itself bypasses the shadow into this frame.
            if (frame_last) begin
                disp_bcd  <= load ? bcd : shadow_bcd;
                disp_dp   <= load ? dp  : shadow_dp;
                frame_cnt <= blink_last ? '0 : frame_cnt + 1'b1;
                if (blink_last) begin
                    blink_phase <= ~blink_phase;
                end
            end
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a per-cycle scoreboard built from a
// cycle-count model plus directed whole-frame checks against literal patterns.
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int GD = 1;
    localparam int BF = 2;
    localparam int FL = N * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        load;
    logic        lz_blank;
    logic [3:0]  blink_mask;
    logic [3:0]  an;
    logic [7:0]  seg;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .GUARD        (GD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd        (bcd),
        .dp         (dp),
        .load       (load),
        .lz_blank   (lz_blank),
        .blink_mask (blink_mask),
        .an         (an),
        .seg        (seg)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [11:0] exp_q [$];
    int          st       = 0;
    logic [15:0] m_shadow_bcd = '0;
    logic [15:0] m_disp_bcd   = '0;
    logic [3:0]  m_shadow_dp  = '1;
    logic [3:0]  m_disp_dp    = '1;

    function automatic logic [6:0] pat(input logic [3:0] c);
        case (c)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected {an, seg} registered at the coming edge, from state count st.
    function automatic logic [11:0] model_out();
        int         d;
        int         f;
        logic       blank;
        logic [3:0] a;
        if ((st % SD) < GD) return 12'hFFF;
        d     = (st / SD) % N;
        f     = st / FL;
        a     = 4'hF;
        a[d]  = 1'b0;
        blank = 1'b0;
        if (lz_blank && d > 0) begin
            blank = 1'b1;
            for (int j = d; j < N; j++) begin
                if (m_disp_bcd[4*j +: 4] != 4'd0 || !m_disp_dp[j]) blank = 1'b0;
            end
        end
        if (((f / BF) % 2) == 1 && blink_mask[d]) blank = 1'b1;
        return {a, blank ? 8'hFF : {m_disp_dp[d], pat(m_disp_bcd[4*d +: 4])}};
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got an=%b seg=%h, want an=%b seg=%h",
                      tag, obs[11:8], obs[7:0], exp[11:8], exp[7:0]);
    endtask

    task automatic step();
        logic [11:0] e;
        if (rst) begin
            exp_q.push_back(12'hFFF);
            st           = 0;
            m_shadow_bcd = '0;
            m_disp_bcd   = '0;
            m_shadow_dp  = '1;
            m_disp_dp    = '1;
        end else begin
            exp_q.push_back(model_out());
            if (((st + 1) % FL) == 0) begin
                m_disp_bcd = load ? bcd : m_shadow_bcd;
                m_disp_dp  = load ? dp  : m_shadow_dp;
            end
            if (load) begin
                m_shadow_bcd = bcd;
                m_shadow_dp  = dp;
            end
            st++;
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("scan", {an, seg}, e);
    endtask

    task automatic run_to_frame_start();
        while ((st % FL) != 0) step();
    endtask

    // One full frame against literal per-digit segment bytes (digit 0 first).
    task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0]  ev [4];
        logic [3:0]  a;
        logic [11:0] want;
        int          d;
        ev = '{e0, e1, e2, e3};
        run_to_frame_start();
        for (int k = 0; k < FL; k++) begin
            step();
            d = k / SD;
            if ((k % SD) < GD) begin
                want = 12'hFFF;
            end else begin
                a    = 4'hF;
                a[d] = 1'b0;
                want = {a, ev[d]};
            end
            check(tag, {an, seg}, want);
        end
    endtask

    initial begin
        rst = 1'b1; bcd = '0; dp = 4'hF; load = 1'b0; lz_blank = 1'b0; blink_mask = '0;
        step();
        step();
        check("reset_state", {an, seg}, 12'hFFF);
        rst = 1'b0;

        bcd = 16'h1234; load = 1'b1; step(); load = 1'b0;
        check_frame("digits_1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        bcd = 16'h0070; lz_blank = 1'b1; load = 1'b1; step(); load = 1'b0;
        check_frame("lz_on_0070", 8'hC0, 8'hF8, 8'hFF, 8'hFF);
        lz_blank = 1'b0;
        check_frame("lz_off_0070", 8'hC0, 8'hF8, 8'hC0, 8'hC0);

        bcd = 16'h0000; lz_blank = 1'b1; load = 1'b1; step(); load = 1'b0;
        check_frame("lz_all_zero", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
        dp = 4'b1011; load = 1'b1; step(); load = 1'b0;
        check_frame("lz_dp2", 8'hC0, 8'hC0, 8'h40, 8'hFF);
        dp = 4'hF; lz_blank = 1'b0;

        // Load on the frame-wrap edge itself shows in the frame that starts there.
        while (((st + 1) % FL) != 0) step();
        bcd = 16'h5678; load = 1'b1; step(); load = 1'b0; bcd = 16'h0000;
        check_frame("load_at_wrap", 8'h80, 8'hF8, 8'h82, 8'h92);

        for (int i = 0; i < 40; i++) begin
            bcd  = 16'($urandom);
            dp   = 4'($urandom);
            load = 1'b1;
            step();
        end
        load = 1'b0;
        repeat (2 * FL) step();
        dp = 4'hF;

        rst = 1'b1; step(); rst = 1'b0;
        bcd = 16'h1234; blink_mask = 4'b0001; load = 1'b1; step(); load = 1'b0;
        check_frame("blink_on_a",  8'h99, 8'hB0, 8'hA4, 8'hF9);
        check_frame("blink_off_a", 8'hFF, 8'hB0, 8'hA4, 8'hF9);
        check_frame("blink_off_b", 8'hFF, 8'hB0, 8'hA4, 8'hF9);
        check_frame("blink_on_b",  8'h99, 8'hB0, 8'hA4, 8'hF9);
        blink_mask = '0;

        bcd = 16'h000A; dp = 4'b1110; load = 1'b1; step(); load = 1'b0;
        check_frame("code_a_dp", 8'h7F, 8'hC0, 8'hC0, 8'hC0);

        while ((st % SD) != 2) step();
        rst = 1'b1; step();
        check("rst_mid_slot", {an, seg}, 12'hFFF);
        rst = 1'b0; step();
        check("rst_guard", {an, seg}, 12'hFFF);
        step();
        check("rst_first_digit", {an, seg}, {4'b1110, 8'hC0});
        check_frame("post_reset", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
